rounding_shift_pipe: RTL and testbench

//  Pipelined, multi-channel signed divide-by-power-of-two with round-half-away-from-zero and output saturation.

---
 rtl/rsp_pkg.sv | 24 ++
 rtl/rsp_round_shift.sv | 49 ++++
 rtl/rounding_shift_pipe.sv | 148 ++++++++++++++
 tb/tb_rounding_shift_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_pkg.sv
// rsp_pkg -- shared widths and saturation limits for rounding_shift_pipe.
// Revision 1.0
`default_nettype none

package rsp_pkg;

  localparam int c_DATA_W  = 32;
  localparam int c_OUT_W   = 8;
  localparam int c_SHIFT_W = 5;
  localparam int c_CH_N    = 16;
  localparam int c_CH_W    = 4;
  localparam int c_CNT_W   = 16;

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsp_round_shift.sv
// rsp_round_shift -- magnitude round-half-away shift, sign restore and saturation.
// Revision 1.0
`default_nettype none

module rsp_round_shift
  import rsp_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int OUT_W   = c_OUT_W,
  parameter int SHIFT_W = c_SHIFT_W
) (
  input  logic               i_sign,
  input  logic [DATA_W:0]    i_mag,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_sat
);

  // Negative results may reach one further in magnitude than positive ones.
  localparam logic [DATA_W:0] c_POS_LIM = (DATA_W+1)'(sat_max(OUT_W));
  localparam logic [DATA_W:0] c_NEG_LIM = (DATA_W+1)'(-sat_min(OUT_W));

  logic [DATA_W:0]  w_bias;
  logic [DATA_W:0]  w_sum;
  logic [DATA_W:0]  w_rnd;
  logic [OUT_W-1:0] w_low;

  always_comb begin
    w_bias = '0;
    if (i_shift != '0) begin
      w_bias = (DATA_W+1)'(1) << (i_shift - SHIFT_W'(1));
    end
    w_sum  = i_mag + w_bias;
    w_rnd  = w_sum >> i_shift;
    w_low  = w_rnd[OUT_W-1:0];
    o_sat  = 1'b0;
    o_data = i_sign ? -w_low : w_low;
    if (!i_sign && (w_rnd > c_POS_LIM)) begin
      o_data = OUT_W'(sat_max(OUT_W));
      o_sat  = 1'b1;
    end else if (i_sign && (w_rnd > c_NEG_LIM)) begin
      o_data = OUT_W'(sat_min(OUT_W));
      o_sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rounding_shift_pipe.sv
// rounding_shift_pipe -- 2-stage per-channel signed rounding shift with saturation.
// Revision 1.0
`default_nettype none

module rounding_shift_pipe
  import rsp_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int OUT_W   = c_OUT_W,
  parameter int SHIFT_W = c_SHIFT_W,
  parameter int CH_N    = c_CH_N,
  parameter int CH_W    = c_CH_W,
  parameter int CNT_W   = c_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_sat,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_count
);

  logic [SHIFT_W-1:0] r_shift [CH_N];

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [DATA_W:0]    r_s1_mag;
  logic [SHIFT_W-1:0] r_s1_shift;
  logic [CH_W-1:0]    r_s1_ch;

  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [CH_W-1:0]    r_out_ch;
  logic               r_out_sat;
  logic [CNT_W-1:0]   r_sat_count;

  logic               w_adv;
  logic [DATA_W:0]    w_ext;
  logic [DATA_W:0]    w_abs;
  logic [SHIFT_W-1:0] w_s_raw;
  logic [SHIFT_W-1:0] w_s_eff;
  logic [OUT_W-1:0]   w_rs_data;
  logic               w_rs_sat;
  logic               w_sat_inc;

  // Single global stall: both stages advance together whenever the output slot frees.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = rst_n && w_adv;
  assign w_sat_inc = r_out_valid && out_ready && r_out_sat;

  always_comb begin
    w_ext   = {in_data[DATA_W-1], in_data};
    w_abs   = w_ext[DATA_W] ? -w_ext : w_ext;
    w_s_raw = '0;
    if (int'(in_ch) < CH_N) begin
      w_s_raw = r_shift[in_ch];
    end
    w_s_eff = w_s_raw;
    if (int'(w_s_raw) > DATA_W - 1) begin
      w_s_eff = SHIFT_W'(DATA_W - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_N; i++) begin
        r_shift[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_ch) < CH_N)) begin
      r_shift[cfg_ch] <= cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_shift <= '0;
      r_s1_ch    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= in_data[DATA_W-1];
        r_s1_mag   <= w_abs;
        r_s1_shift <= w_s_eff;
        r_s1_ch    <= in_ch;
      end
    end
  end

  rsp_round_shift #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_round_shift (
    .i_sign (r_s1_sign),
    .i_mag  (r_s1_mag),
    .i_shift(r_s1_shift),
    .o_data (w_rs_data),
    .o_sat  (w_rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_rs_data;
        r_out_ch   <= r_s1_ch;
        r_out_sat  <= w_rs_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_inc && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

`default_nettype wire

// File: tb/tb_rounding_shift_pipe.sv
// tb_rounding_shift_pipe -- scoreboard bench for rounding_shift_pipe against an arithmetic model.
// Revision 1.0
`default_nettype none

module tb_rounding_shift_pipe;

  localparam int DATA_W  = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int CH_N    = 16;
  localparam int CH_W    = 4;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic [CH_W-1:0]         ch;
    logic                    sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [CH_W-1:0]    in_ch;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [CH_W-1:0]    out_ch;
  logic               out_sat;
  logic               sat_clr;
  logic [CNT_W-1:0]   sat_count;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   mshift [CH_N];
  longint mcnt = 0;
  int   done_a;

  rounding_shift_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_shift(cfg_shift),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ch    (in_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: quotient rounded to nearest, ties away from zero, then clipped.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] ch);
    exp_t   e;
    longint x, a, m, q, p2;
    int     s;
    x = longint'($signed(d));
    s = (int'(ch) < CH_N) ? mshift[ch] : 0;
    if (s > DATA_W - 1) s = DATA_W - 1;
    a  = (x < 0) ? -x : x;
    p2 = longint'(1) << s;
    m  = a / p2;
    if (2 * (a % p2) >= p2 && s != 0) m = m + 1;
    q  = (x < 0) ? -m : m;
    e.sat = 1'b0;
    if (q > 127) begin
      q = 127;
      e.sat = 1'b1;
    end else if (q < -128) begin
      q = -128;
      e.sat = 1'b1;
    end
    e.data = OUT_W'(q);
    e.ch   = ch;
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t   e;
    logic   hold_pend;
    longint held;
    hold_pend = 1'b0;
    held      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", longint'(out_valid), 1);
          chk("hold_payload", longint'({out_data, out_ch, out_sat}), held);
        end
        hold_pend = out_valid && !out_ready;
        held      = longint'({out_data, out_ch, out_sat});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data %0d ch %0d, expected nothing", $signed(out_data), out_ch);
          end else begin
            e = sb.pop_front();
            chk("out_data", longint'($signed(out_data)), longint'(e.data));
            chk("out_ch", longint'(out_ch), longint'(e.ch));
            chk("out_sat", longint'(out_sat), longint'(e.sat));
            if (!sat_clr && e.sat && mcnt != 65535) mcnt++;
          end
        end
        if (sat_clr) mcnt = 0;
        if (in_valid && in_ready) sb.push_back(model(in_data, in_ch));
        if (cfg_we && int'(cfg_ch) < CH_N) mshift[cfg_ch] = int'(cfg_shift);
      end
    end
  end

  task automatic setcfg(input int ch, input int sh);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_shift = SHIFT_W'(sh);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [CH_W-1:0] ch);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ch    = ch;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, cnt;
    for (int i = 0; i < CH_N; i++) mshift[i] = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_shift = '0;
    in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1; sat_clr = 1'b0;
    #12;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_ch", longint'(out_ch), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_sat_count", longint'(sat_count), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back rounding, no bubbles
    for (int c = 0; c < CH_N; c++) setcfg(c, 4);
    first = -1; last = -1; cnt = 0;
    fork
      begin
        send(32'd40, 4'd0);
        send(32'd24, 4'd0);
        send(-32'sd24, 4'd0);
        send(32'd23, 4'd0);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (first < 0) first = i;
            last = i;
            cnt++;
          end
        end
      end
    join
    chk("t1_out_count", cnt, 4);
    chk("t1_burst_span", last - first + 1, 4);
    drain();

    // Pass-through with saturation
    setcfg(0, 0);
    send(-32'sd200, 4'd0);
    send(32'd127, 4'd0);
    drain();
    chk("t2_sat_count", longint'(sat_count), 1);

    // Largest shift, extreme inputs
    setcfg(0, 31);
    send(32'h8000_0000, 4'd0);
    send(32'h7FFF_FFFF, 4'd0);
    drain();

    // Stall with a continuous stream
    for (int c = 0; c < CH_N; c++) setcfg(c, int'($urandom_range(0, 31)));
    fork
      begin
        for (int i = 0; i < 12; i++) send($urandom, CH_W'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_stall_in_ready", longint'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Per-channel shifts and same-edge config write
    setcfg(3, 2);
    setcfg(5, 1);
    send(32'd6, 4'd3);
    send(32'd6, 4'd5);
    send(32'd6, 4'd3);
    send(32'd6, 4'd5);
    drain();
    cfg_we = 1'b1; cfg_ch = 4'd3; cfg_shift = '0;
    in_valid = 1'b1; in_data = 32'd6; in_ch = 4'd3;
    @(negedge clk);
    chk("t5_same_edge_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    send(32'd6, 4'd3);
    drain();

    // Randomized traffic with backpressure, config writes and clears
    done_a = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send($urandom, CH_W'($urandom));
        end
        done_a = 1;
      end
      begin
        while (done_a == 0) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
          cfg_we    = ($urandom_range(0, 9) == 0);
          cfg_ch    = CH_W'($urandom);
          cfg_shift = SHIFT_W'($urandom);
          sat_clr   = ($urandom_range(0, 19) == 0);
        end
        out_ready = 1'b1; cfg_we = 1'b0; sat_clr = 1'b0;
      end
    join
    drain();
    chk("rand_sat_count", longint'(sat_count), mcnt);

    // Asynchronous reset with samples in flight
    setcfg(3, 2);
    out_ready = 1'b0;
    send(32'd6, 4'd3);
    send(32'd7, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", longint'(out_valid), 0);
    chk("t6_rst_in_ready", longint'(in_ready), 0);
    chk("t6_rst_sat_count", longint'(sat_count), 0);
    chk("t6_rst_out_data", longint'(out_data), 0);
    sb.delete();
    for (int i = 0; i < CH_N; i++) mshift[i] = 0;
    mcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send(32'd300, 4'd3);
    drain();
    chk("t6_sat_count_one", longint'(sat_count), 1);
    out_ready = 1'b0;
    send(-32'sd200, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    sat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    drain();
    chk("t6_clr_wins", longint'(sat_count), 0);
    chk("t6_model_count", longint'(sat_count), mcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
